// File: rtl/spram_bw_pkg.sv
// spram_bw_pkg: shared types and helpers for the spram_bw_model SRAM stand-in.
package spram_bw_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_WAKE  = 2'd1,
    ST_READY = 2'd2,
    ST_SLEEP = 2'd3
  } state_t;

  // Number of byte lanes (and write-enable bits) for a given data width.
  function automatic int byte_lanes(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/spram_bw_model_if.sv
// spram_bw_model_if: access/sleep bus of the SRAM model.
// master drives the access and sleep request, slave (the memory) returns Q/RDY.
interface spram_bw_model_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 12
);
  logic                   CEn;
  logic [WIDTH/8-1:0]     WEn;
  logic [AW-1:0]          A;
  logic [WIDTH-1:0]       D;
  logic                   SLP;
  logic [WIDTH-1:0]       Q;
  logic                   RDY;

  modport master (output CEn, WEn, A, D, SLP, input Q, RDY);
  modport slave  (input CEn, WEn, A, D, SLP, output Q, RDY);
endinterface

// File: rtl/spram_bw_array.sv
// spram_bw_array: word storage with byte-masked synchronous write and an
// asynchronous read of the addressed word, so a registered reader taking the
// same edge as a write captures the pre-write contents. Addresses at or above
// DEPTH never write and read back as zero. The clear port has priority and is
// only driven while the owner is zeroing the array.
module spram_bw_array
  import spram_bw_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                           CLK,
  input  logic                           wr_en,
  input  logic [byte_lanes(WIDTH)-1:0]   wen_n,
  input  logic [AW-1:0]                  addr,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  input  logic                           clr_en,
  input  logic [AW-1:0]                  clr_addr
);

  localparam int NB = byte_lanes(WIDTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;

  assign in_range = ({1'b0, addr} < DEPTH_W);

  // Clear or byte-masked write; no reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_en && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (!wen_n[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = in_range ? mem[addr] : '0;

endmodule

// File: rtl/spram_bw_model.sv
// spram_bw_model: parametrised single-port SRAM functional model with byte
// write enables, optional output register (OUT_REG) and a sleep/wake
// sequencer driving RDY.
// Optional feature macro: SPRAM_BW_INIT_CLEAR_EN -- when defined, every reset
// walks the array writing zeros (CLEAR state) before the wake sequence.
module spram_bw_model
  import spram_bw_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4096,
  parameter int AW          = $clog2(DEPTH),
  parameter int WAKE_CYCLES = 4,
  parameter int OUT_REG     = 0
) (
  input  logic               CLK,
  input  logic               RST,
  spram_bw_model_if.slave    bus
);

  localparam int             WCW       = $clog2(WAKE_CYCLES + 1);
  localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES);

  state_t           state, state_nxt;
  logic [WCW-1:0]   wake_cnt, wake_cnt_nxt;
  logic             access;
  logic             keep_out;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] p_q;
  logic             rdy_q;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic             clr_last;

`ifdef SPRAM_BW_INIT_CLEAR_EN
  localparam state_t        RESET_ST = ST_CLEAR;
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
  logic [AW-1:0] clr_cnt;

  // Clear address walks 0..DEPTH-1 while in CLEAR; reset restarts it at 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  assign clr_en   = (state == ST_CLEAR);
  assign clr_addr = clr_cnt;
  assign clr_last = (clr_cnt == CLR_LAST);
`else
  localparam state_t RESET_ST = ST_WAKE;
  assign clr_en   = 1'b0;
  assign clr_addr = '0;
  assign clr_last = 1'b0;
`endif

  // State and wake down-counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= RESET_ST;
      wake_cnt <= WAKE_LOAD;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_cnt_nxt;
    end
  end

  // Next-state: wake counter reaching zero enters READY; SLP reloads it.
  always_comb begin
    state_nxt    = state;
    wake_cnt_nxt = wake_cnt;
    case (state)
      ST_CLEAR: begin
        if (clr_last) begin
          state_nxt    = ST_WAKE;
          wake_cnt_nxt = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (bus.SLP) begin
          state_nxt    = ST_SLEEP;
          wake_cnt_nxt = WAKE_LOAD;
        end else begin
          wake_cnt_nxt = wake_cnt - 1'b1;
          if (wake_cnt == WCW'(1)) state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.SLP) state_nxt = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (!bus.SLP) begin
          state_nxt    = ST_WAKE;
          wake_cnt_nxt = WAKE_LOAD;
        end
      end
      default: state_nxt = RESET_ST;
    endcase
  end

  // Accesses only execute in READY; the edge that leaves for SLEEP still writes.
  assign access   = (state == ST_READY) && !bus.CEn;
  assign keep_out = (state == ST_READY) && !bus.SLP;

  spram_bw_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK      (CLK),
    .wr_en    (access),
    .wen_n    (bus.WEn),
    .addr     (bus.A),
    .wdata    (bus.D),
    .rdata    (rdata),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // First read stage: captures pre-write data on access, holds otherwise,
  // forced to zero outside READY and on the edge heading to SLEEP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           p_q <= '0;
    else if (!keep_out) p_q <= '0;
    else if (access)   p_q <= rdata;
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] q_q;
      // Extra output stage; advances every READY cycle, flushed otherwise.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)            q_q <= '0;
        else if (!keep_out) q_q <= '0;
        else                q_q <= p_q;
      end
      assign bus.Q = q_q;
    end else begin : g_noreg
      assign bus.Q = p_q;
    end
  endgenerate

  // RDY mirrors the registered state being READY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdy_q <= 1'b0;
    else     rdy_q <= (state_nxt == ST_READY);
  end

  assign bus.RDY = rdy_q;

endmodule
